seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Multi-cycle arithmetic stage directly upstream of the accumulator in the single-cycle CPU datapath.
- Takes operand A (accumulator OUT fed back) and operand B (immediate or memory data) and computes PASS, ADD, SUB or MUL.
- Presents a registered result plus a one-cycle write strobe that drives the accumulator's EN, so the accumulator captures exactly one result per START.
- ADD, SUB and PASS complete in one cycle; MUL is an iterative shift-add taking up to WIDTH cycles.

Parameters:
WIDTH, 8, data width of A, B and RES; also the MUL iteration count.

Ports:
CLK  input  1  clock; all state updates on the rising edge.
RST_N  input  1  synchronous, active-low reset, sampled on the CLK rising edge.
START  input  1  request; sampled only in IDLE.
OP  input  2  operation: 00 PASS B, 01 ADD, 10 SUB, 11 MUL.
A  input  WIDTH  operand A, from accumulator OUT.
B  input  WIDTH  operand B.
RES  output  WIDTH  registered result, wired to accumulator IN.
C  output  1  registered carry / borrow / overflow flag.
ACC_EN  output  1  one-cycle write strobe, wired to accumulator EN.
BUSY  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (RST_N low at an edge):
  - State goes to IDLE; RES=0, C=0, ACC_EN=0, BUSY=0; internal counter and product registers cleared.
  - Reset applies mid-MUL and during DONE; it aborts the operation with no ACC_EN pulse.
- States:
  - IDLE: waiting; ACC_EN=0, BUSY=0.
  - MUL: iterating; ACC_EN=0, BUSY=1.
  - DONE: result valid; ACC_EN=1, BUSY=1; lasts exactly one cycle.
- Transitions:
  - IDLE & START & OP!=11 → DONE.
  - IDLE & START & OP==11 → MUL.
  - MUL & last iteration → DONE.
  - DONE → IDLE, unconditionally.
- Operand capture: A, B and OP are latched at the edge where START is accepted. Later changes have no effect on the operation in flight.
- START handling: START while BUSY=1 is ignored, not queued. START is level-sampled, so START held high re-triggers on the first IDLE cycle.
- Single-cycle ops: RES and C are loaded at the accepting edge k. ACC_EN is high from edge k to edge k+1, so the accumulator captures at edge k+1.
  - PASS: RES=B, C=0.
  - ADD: {C,RES}=A+B, where C is the carry out.
  - SUB: RES=A-B modulo 2^WIDTH; C=1 iff A<B (borrow).
- MUL:
  - At the accepting edge k: product P (2*WIDTH bits) =0, multiplicand M (2*WIDTH bits) =A zero-extended, multiplier Q=B, counter=0.
  - Each MUL edge: if Q[0], P=P+M; then M<<=1, Q>>=1, counter+=1.
  - When the counter reaches WIDTH (edge k+WIDTH), the state goes to DONE with RES=P[WIDTH-1:0] and C=|P[2*WIDTH-1:WIDTH] (unsigned overflow), using the final accumulated P.
  - ACC_EN is high for the cycle after edge k+WIDTH; total latency is WIDTH+1 edges to the accumulator capture.
- Hold rules:
  - RES and C hold their last value until the next completion; they update only on entry to DONE.
  - ACC_EN is never high for two consecutive cycles.
- Arithmetic is unsigned throughout; wrap-around is modulo 2^WIDTH, with C as the only overflow indication.

Optional Feature:
- Macro: SEQ_ALU_MUL_EARLY_EXIT_EN.
- Defined: on any MUL edge where the post-shift Q equals 0, the state goes to DONE at that edge with the result as above, regardless of the counter. At least one MUL cycle always occurs, so B=0 or B=1 finish at edge k+1 and ACC_EN is high for the cycle after k+1. BUSY and DONE semantics are unchanged.
- Undefined: MUL always takes exactly WIDTH iterations.
- Results are bit-identical either way; only latency differs.

Test Plan:
- Reset: RST_N low for 2 edges, including once mid-MUL → RES=0x00, C=0, BUSY=0, ACC_EN=0; no strobe appears afterwards.
- ADD/SUB/PASS (WIDTH=8):
  - ADD A=0x05, B=0x0A → RES=0x0F, C=0, ACC_EN high exactly 1 cycle after the accepting edge.
  - ADD 0xFF+0x01 → RES=0x00, C=1.
  - SUB 0x03-0x05 → RES=0xFE, C=1.
  - PASS B=0x5A → RES=0x5A, C=0.
- MUL latency (macro undefined): A=0x0C, B=0x0B → BUSY high for 9 cycles; ACC_EN in the 9th cycle; RES=0x84, C=0. A=0x10, B=0x20 → RES=0x00, C=1.
- MUL early exit (macro defined): A=0x0C, B=0x01 → ACC_EN high in the 2nd cycle after acceptance, RES=0x0C. A=0x0C, B=0x0B → ACC_EN in the 5th cycle, RES=0x84.
- Ignored START: pulse START with OP=01 during MUL → exactly one ACC_EN with the MUL result. Change A/B mid-MUL → result unaffected.
- Accumulator loop: seq_alu RES/ACC_EN wired to accumulator IN/EN, A fed from accumulator OUT. PASS 0x05, ADD 0x03, MUL 0x02 → accumulator reads 0x05, 0x08, 0x10; its Z flag stays 0. SUB 0x10 → accumulator 0x00, Z=1.

Source files
------------

// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu
//
// Multi-cycle arithmetic stage that feeds the accumulator of the CPU datapath.
// Operand A comes back from the accumulator output. Operand B is an immediate
// or memory data. The operations are PASS B, ADD, SUB and an iterative
// shift-add MUL.
//
// Every accepted START produces exactly one registered result. That result is
// qualified by a one-cycle ACC_EN strobe, which drives the accumulator EN.
//
// Ports
//   CLK     in   1      clock, all state updates on the rising edge
//   RST_N   in   1      synchronous active-low reset
//   START   in   1      request, sampled only while idle (level sampled)
//   OP      in   2      00 PASS B, 01 ADD, 10 SUB, 11 MUL
//   A       in   WIDTH  operand A (accumulator OUT)
//   B       in   WIDTH  operand B
//   RES     out  WIDTH  registered result (accumulator IN)
//   C       out  1      registered carry / borrow / unsigned-overflow flag
//   ACC_EN  out  1      one-cycle write strobe (accumulator EN)
//   BUSY    out  1      high whenever the FSM is not idle
//
// Optional build macro
//   SEQ_ALU_MUL_EARLY_EXIT_EN
//     When defined, MUL finishes as soon as the remaining multiplier bits are
//     all zero. At least one iteration is always taken. The result is
//     identical to the full-length multiply; only the latency shrinks.
//     When undefined, MUL always takes exactly WIDTH iterations.
// -----------------------------------------------------------------------------
module seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [1:0]       OP,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] RES,
    output logic             C,
    output logic             ACC_EN,
    output logic             BUSY
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int PW    = 2 * WIDTH;

    localparam logic [1:0] OP_PASS = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_MUL  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MUL  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_res;
    logic               r_c;
    logic               r_acc_en;
    logic               r_busy;
    logic [PW-1:0]      r_p;     // running product
    logic [PW-1:0]      r_m;     // multiplicand, shifted left each iteration
    logic [WIDTH-1:0]   r_q;     // multiplier, shifted right each iteration
    logic [CNT_W-1:0]   r_cnt;   // iterations completed

    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_diff;
    logic               w_borrow;
    logic [PW-1:0]      w_p_next;
    logic [WIDTH-1:0]   w_q_shift;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               w_mul_last;

    // Any bit set in the upper half of the double-width product means the
    // result does not fit in WIDTH bits.
    function automatic logic mul_overflow(input logic [PW-1:0] p);
        return |p[PW-1:WIDTH];
    endfunction

    // Single-cycle datapath, evaluated on the live operands at the accept edge.
    // A zero-extended sum keeps the carry out as its top bit.
    assign w_sum    = {1'b0, A} + {1'b0, B};
    assign w_diff   = A - B;
    assign w_borrow = (A < B);

    // One shift-add step. The add uses the pre-shift multiplier LSB.
    assign w_p_next   = r_q[0] ? (r_p + r_m) : r_p;
    assign w_q_shift  = r_q >> 1;
    assign w_cnt_next = r_cnt + CNT_W'(1);

`ifdef SEQ_ALU_MUL_EARLY_EXIT_EN
    // Once no multiplier bits remain, later iterations cannot change P.
    assign w_mul_last = (w_cnt_next == CNT_W'(WIDTH)) || (w_q_shift == '0);
`else
    assign w_mul_last = (w_cnt_next == CNT_W'(WIDTH));
`endif

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state  <= S_IDLE;
            r_res    <= '0;
            r_c      <= 1'b0;
            r_acc_en <= 1'b0;
            r_busy   <= 1'b0;
            r_p      <= '0;
            r_m      <= '0;
            r_q      <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_acc_en <= 1'b0;
                    if (START) begin
                        r_busy <= 1'b1;
                        if (OP == OP_MUL) begin
                            // Operands are latched here, so later changes
                            // on A/B cannot disturb the iteration.
                            r_p     <= '0;
                            r_m     <= {{WIDTH{1'b0}}, A};
                            r_q     <= B;
                            r_cnt   <= '0;
                            r_state <= S_MUL;
                        end else begin
                            case (OP)
                                OP_ADD: begin
                                    r_res <= w_sum[WIDTH-1:0];
                                    r_c   <= w_sum[WIDTH];
                                end
                                OP_SUB: begin
                                    r_res <= w_diff;
                                    r_c   <= w_borrow;
                                end
                                default: begin
                                    r_res <= B;
                                    r_c   <= 1'b0;
                                end
                            endcase
                            r_acc_en <= 1'b1;
                            r_state  <= S_DONE;
                        end
                    end
                end

                S_MUL: begin
                    r_p   <= w_p_next;
                    r_m   <= r_m << 1;
                    r_q   <= w_q_shift;
                    r_cnt <= w_cnt_next;
                    if (w_mul_last) begin
                        // Use this edge's accumulated product, not the
                        // registered one, so no extra cycle is needed.
                        r_res    <= w_p_next[WIDTH-1:0];
                        r_c      <= mul_overflow(w_p_next);
                        r_acc_en <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end

                S_DONE: begin
                    // The strobe lasts exactly one cycle, and START is not
                    // looked at here. Back-to-back strobes are impossible.
                    r_acc_en <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end

                default: begin
                    r_acc_en <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    assign RES    = r_res;
    assign C      = r_c;
    assign ACC_EN = r_acc_en;
    assign BUSY   = r_busy;

endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RST_N = 1'b0;
    logic         START = 1'b0;
    logic [1:0]   OP = 2'b00;
    logic [W-1:0] a_drv = '0;
    logic [W-1:0] B = '0;
    logic [W-1:0] w_a;
    logic [W-1:0] RES;
    logic         C;
    logic         ACC_EN;
    logic         BUSY;

    // Accumulator placed downstream of the ALU, used for the closed-loop test.
    logic         loop_mode = 1'b0;
    logic [W-1:0] acc_q;
    logic         acc_z;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic prev_en = 1'b0;

    typedef struct {
        logic [W-1:0] res;
        logic         c;
        int           cyc;
        string        tag;
    } exp_t;

    exp_t sb[$];
    exp_t e_mon;

    assign w_a = loop_mode ? acc_q : a_drv;

    seq_alu #(.WIDTH(W)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .START (START),
        .OP    (OP),
        .A     (w_a),
        .B     (B),
        .RES   (RES),
        .C     (C),
        .ACC_EN(ACC_EN),
        .BUSY  (BUSY)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (!RST_N)      acc_q <= '0;
        else if (ACC_EN) acc_q <= RES;
    end
    assign acc_z = (acc_q == '0);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
        logic [2*W-1:0] p;
        case (op)
            2'b00: return {1'b0, b};
            2'b01: return {1'b0, a} + {1'b0, b};
            2'b10: return {(a < b), a - b};
            default: begin
                p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                return {(p[2*W-1:W] != '0), p[W-1:0]};
            end
        endcase
    endfunction

    // Edges from acceptance to the DONE entry.
    function automatic int lat_of(input logic [1:0] op, input logic [W-1:0] b);
        if (op != 2'b11) return 0;
`ifdef SEQ_ALU_MUL_EARLY_EXIT_EN
        for (int i = W - 1; i >= 0; i--) if (b[i]) return i + 1;
        return 1;
`else
        return W;
`endif
    endfunction

    // Scoreboard consumer: every strobe must match the oldest expectation.
    always @(negedge CLK) begin
        if (RST_N && ACC_EN) begin
            if (prev_en) check("acc_en_double", 1, 0);
            if (sb.size() == 0) begin
                check("spurious_strobe", 1, 0);
            end else begin
                e_mon = sb.pop_front();
                check({e_mon.tag, "_res"}, 32'(RES), 32'(e_mon.res));
                check({e_mon.tag, "_c"}, 32'(C), 32'(e_mon.c));
                check({e_mon.tag, "_strobe_cycle"}, cyc, e_mon.cyc);
            end
        end
        prev_en = ACC_EN;
    end

    task automatic push_exp(input string tag, input logic [1:0] op,
                            input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] m;
        exp_t e;
        m = model(op, a, b);
        e.res = m[W-1:0];
        e.c   = m[W];
        e.cyc = cyc + 1 + lat_of(op, b);
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic do_op(input string tag, input logic [1:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        int busy_n;
        bit done;
        @(negedge CLK);
        START = 1'b1; OP = op; a_drv = a; B = b;
        push_exp(tag, op, a, b);
        busy_n = 0;
        done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge CLK);
            START = 1'b0;
            if (BUSY) busy_n++;
            else done = 1;
        end
        check({tag, "_busy_len"}, busy_n, lat_of(op, b) + 1);
        check({tag, "_drained"}, sb.size(), 0);
    endtask

    initial begin
        logic [1:0]   rop;
        logic [W-1:0] ra, rb;
        logic [W:0]   m;
        int           n;

        // Reset held for two edges
        RST_N = 1'b0;
        repeat (2) @(negedge CLK);
        check("rst_res", 32'(RES), 0);
        check("rst_c", 32'(C), 0);
        check("rst_busy", 32'(BUSY), 0);
        check("rst_acc_en", 32'(ACC_EN), 0);
        RST_N = 1'b1;
        @(negedge CLK);

        do_op("add_basic", 2'b01, 8'h05, 8'h0A);
        do_op("add_carry", 2'b01, 8'hFF, 8'h01);
        do_op("sub_borrow", 2'b10, 8'h03, 8'h05);
        do_op("sub_equal", 2'b10, 8'h77, 8'h77);
        do_op("pass", 2'b00, 8'h33, 8'h5A);
        repeat (4) @(negedge CLK);
        check("hold_res", 32'(RES), 32'h5A);
        check("hold_c", 32'(C), 0);

        do_op("mul_0c_0b", 2'b11, 8'h0C, 8'h0B);
        do_op("mul_ovf", 2'b11, 8'h10, 8'h20);
        do_op("mul_b1", 2'b11, 8'h0C, 8'h01);
        do_op("mul_b0", 2'b11, 8'h0C, 8'h00);
        do_op("mul_ff", 2'b11, 8'hFF, 8'hFF);

        for (int i = 0; i < 8; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            do_op("rand", rop, ra, rb);
        end

        // START during MUL is ignored, and operand changes have no effect.
        @(negedge CLK);
        START = 1'b1; OP = 2'b11; a_drv = 8'h0C; B = 8'h0B;
        push_exp("mul_ignore", 2'b11, 8'h0C, 8'h0B);
        @(negedge CLK);
        START = 1'b0;
        repeat (2) @(negedge CLK);
        START = 1'b1; OP = 2'b01; a_drv = 8'hFF; B = 8'hFF;
        @(negedge CLK);
        START = 1'b0;
        n = 0;
        while (BUSY && n < 40) begin @(negedge CLK); n++; end
        check("ignore_timeout", 32'(n < 40), 1);
        repeat (5) @(negedge CLK);
        check("ignore_drained", sb.size(), 0);

        // Reset in the middle of a MUL aborts it without a strobe.
        @(negedge CLK);
        START = 1'b1; OP = 2'b11; a_drv = 8'hFF; B = 8'hFF;
        @(negedge CLK);
        START = 1'b0;
        repeat (2) @(negedge CLK);
        check("midmul_busy", 32'(BUSY), 1);
        RST_N = 1'b0;
        repeat (2) @(negedge CLK);
        check("midrst_res", 32'(RES), 0);
        check("midrst_c", 32'(C), 0);
        check("midrst_busy", 32'(BUSY), 0);
        check("midrst_acc_en", 32'(ACC_EN), 0);
        RST_N = 1'b1;
        repeat (15) @(negedge CLK);
        check("postrst_busy", 32'(BUSY), 0);

        // Closed loop through the accumulator.
        loop_mode = 1'b1;
        do_op("loop_pass", 2'b00, acc_q, 8'h05);
        check("loop_acc1", 32'(acc_q), 32'h05);
        check("loop_z1", 32'(acc_z), 0);
        do_op("loop_add", 2'b01, acc_q, 8'h03);
        check("loop_acc2", 32'(acc_q), 32'h08);
        check("loop_z2", 32'(acc_z), 0);
        do_op("loop_mul", 2'b11, acc_q, 8'h02);
        check("loop_acc3", 32'(acc_q), 32'h10);
        check("loop_z3", 32'(acc_z), 0);
        m = model(2'b10, acc_q, 8'h10);
        do_op("loop_sub", 2'b10, acc_q, 8'h10);
        check("loop_acc4", 32'(acc_q), 32'(m[W-1:0]));
        check("loop_z4", 32'(acc_z), 1);
        loop_mode = 1'b0;

        repeat (3) @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
